// File: rtl/lc3b_types.sv
// Shared types and helpers for the L2 data array.
// - lc3b_burst / lc3b_set_l2 : line and L2 set-index types.
// - L2_WAYS / L2_SETS        : default L2 geometry.
// - plru_victim / plru_update : tree-PLRU helpers. The tree is stored heap-style:
//   node 0 is the root and node n has children 2n+1 (lower half) and 2n+2 (upper half).
//   A node bit of 0 points to the lower half. The helpers take up to 8 ways and use
//   the number of levels given by the ways argument.
package lc3b_types;

  localparam int L2_WAYS  = 4;
  localparam int L2_SETS  = 32;

  typedef logic [255:0]                 lc3b_burst;
  typedef logic [$clog2(L2_SETS)-1:0]   lc3b_set_l2;
  typedef logic [2:0]                   plru_way_t;
  typedef logic [6:0]                   plru_bits_t;

  // Follow the tree from the root. Each node bit chooses the half, and that bit
  // becomes the next victim-index bit, starting with the MSB.
  function automatic plru_way_t plru_victim(input plru_bits_t bits, input int ways);
    int        levels;
    plru_way_t node;
    plru_way_t v;
    levels = $clog2(ways);
    node   = '0;
    v      = '0;
    for (int l = 0; l < 3; l++) begin
      if (l < levels) begin
        v    = {v[1:0], bits[node]};
        node = {node[1:0], 1'b1} + {2'b00, bits[node]};
      end
    end
    return v;
  endfunction

  // Set each node on the path to 'way' so that it points to the other half.
  function automatic plru_bits_t plru_update(input plru_bits_t bits, input plru_way_t way,
                                             input int ways);
    int         levels;
    plru_way_t  node;
    plru_way_t  w;
    plru_bits_t r;
    logic       d;
    levels = $clog2(ways);
    r      = bits;
    node   = '0;
    w      = way << (3 - levels);
    for (int l = 0; l < 3; l++) begin
      if (l < levels) begin
        d       = w[2];
        r[node] = ~d;
        node    = {node[1:0], 1'b1} + {2'b00, d};
        w       = {w[1:0], 1'b0};
      end
    end
    return r;
  endfunction

  // Return the index of the lowest set bit. The result is 0 when v is all zero.
  function automatic plru_way_t lowest_one(input logic [7:0] v);
    plru_way_t r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/data_array_nway_plru_tree.sv
// Per-set tree-PLRU state, with WAYS-1 bits per set.
// Ports:
//   clk, rst_n          clock, async active-low reset (clears all bits)
//   flush               clears every set in one cycle
//   upd_en/set/way      update from a write (applied first)
//   touch_en/set/way    explicit touch (applied after the write update)
//   vic_set / vic_way   combinational PLRU victim for vic_set, taken from the
//                       next-state bits so that a read sees same-cycle updates
module plru_tree
  import lc3b_types::*;
#(
  parameter int WAYS = L2_WAYS,
  parameter int SETS = L2_SETS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    upd_en,
  input  logic [$clog2(SETS)-1:0] upd_set,
  input  logic [$clog2(WAYS)-1:0] upd_way,
  input  logic                    touch_en,
  input  logic [$clog2(SETS)-1:0] touch_set,
  input  logic [$clog2(WAYS)-1:0] touch_way,
  input  logic [$clog2(SETS)-1:0] vic_set,
  output logic [$clog2(WAYS)-1:0] vic_way
);

  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  logic [WAYS-2:0] bits_q [SETS];
  logic [WAYS-2:0] bits_d [SETS];

  always_comb begin
    plru_bits_t b;
    for (int s = 0; s < SETS; s++) begin
      b = plru_bits_t'(bits_q[s]);
      if (upd_en && upd_set == SET_W'(s)) begin
        b = plru_update(b, plru_way_t'(upd_way), WAYS);
      end
      if (touch_en && touch_set == SET_W'(s)) begin
        b = plru_update(b, plru_way_t'(touch_way), WAYS);
      end
      bits_d[s] = flush ? '0 : (WAYS-1)'(b);
    end
    vic_way = WAY_W'(plru_victim(plru_bits_t'(bits_d[vic_set]), WAYS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) bits_q[s] <= '0;
    end else begin
      bits_q <= bits_d;
    end
  end

endmodule

// File: rtl/data_array_nway.sv
// N-way set-associative data array. It stores line data, per-way valid bits and
// tree-PLRU state.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   rd_en, rd_set                     read request for all ways of a set
//   rd_data, rd_vbits, rd_victim      registered read results, held between reads
//   rd_valid                          one-cycle pulse after each accepted read
//   wr_en, wr_set, wr_hit,            write: a nonzero wr_hit writes the masked words
//   wr_fill_way, wr_mask, wr_data       to the lowest hit way; zero fills wr_fill_way
//   touch_en, touch_set, touch_way    mark a way most-recently-used
//   flush                             invalidate everything; a write or touch in the
//                                     same cycle is dropped
// A read that hits the set being written sees the post-write state (write-first).
module data_array_nway
  import lc3b_types::*;
#(
  parameter int WAYS   = L2_WAYS,
  parameter int SETS   = L2_SETS,
  parameter int LINE_W = $bits(lc3b_burst),
  parameter int WORD_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_en,
  input  logic [$clog2(SETS)-1:0]  rd_set,
  output logic [WAYS*LINE_W-1:0]   rd_data,
  output logic [WAYS-1:0]          rd_vbits,
  output logic [$clog2(WAYS)-1:0]  rd_victim,
  output logic                     rd_valid,
  input  logic                     wr_en,
  input  logic [$clog2(SETS)-1:0]  wr_set,
  input  logic [WAYS-1:0]          wr_hit,
  input  logic [$clog2(WAYS)-1:0]  wr_fill_way,
  input  logic [LINE_W/WORD_W-1:0] wr_mask,
  input  logic [LINE_W-1:0]        wr_data,
  input  logic                     touch_en,
  input  logic [$clog2(SETS)-1:0]  touch_set,
  input  logic [$clog2(WAYS)-1:0]  touch_way,
  input  logic                     flush
);

  localparam int WAY_W  = $clog2(WAYS);
  localparam int NWORDS = LINE_W / WORD_W;

  // Line storage has no reset. Valid bits control whether stale data is visible.
  logic [LINE_W-1:0] mem_q [SETS][WAYS];

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   valid_d [SETS];

  logic [WAYS*LINE_W-1:0] rd_data_q,   rd_data_d;
  logic [WAYS-1:0]        rd_vbits_q,  rd_vbits_d;
  logic [WAY_W-1:0]       rd_victim_q, rd_victim_d;
  logic                   rd_valid_q,  rd_valid_d;

  logic              wr_go;
  logic              touch_go;
  logic              wr_is_hit;
  logic [WAY_W-1:0]  wr_tgt;
  logic [LINE_W-1:0] wr_line;
  logic [WAY_W-1:0]  plru_vic;

  // Write target, and the merged line that the write will store.
  always_comb begin
    wr_go     = wr_en & ~flush;
    touch_go  = touch_en & ~flush;
    wr_is_hit = |wr_hit;
    wr_tgt    = wr_is_hit ? WAY_W'(lowest_one(8'(wr_hit))) : wr_fill_way;
    wr_line   = wr_data;
    if (wr_is_hit) begin
      for (int k = 0; k < NWORDS; k++) begin
        if (!wr_mask[k]) begin
          wr_line[k*WORD_W +: WORD_W] = mem_q[wr_set][wr_tgt][k*WORD_W +: WORD_W];
        end
      end
    end
  end

  // Only a fill changes a valid bit. A flush clears all of them.
  always_comb begin
    for (int s = 0; s < SETS; s++) valid_d[s] = flush ? '0 : valid_q[s];
    if (wr_go && !wr_is_hit) valid_d[wr_set][wr_fill_way] = 1'b1;
  end

  plru_tree #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_plru (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .upd_en    (wr_go),
    .upd_set   (wr_set),
    .upd_way   (wr_tgt),
    .touch_en  (touch_go),
    .touch_set (touch_set),
    .touch_way (touch_way),
    .vic_set   (rd_set),
    .vic_way   (plru_vic)
  );

  // Read response is built from the post-write state, and invalid ways read as zero.
  always_comb begin
    logic [LINE_W-1:0] line;
    rd_valid_d  = rd_en;
    rd_data_d   = rd_data_q;
    rd_vbits_d  = rd_vbits_q;
    rd_victim_d = rd_victim_q;
    line        = '0;
    if (rd_en) begin
      rd_vbits_d = valid_d[rd_set];
      for (int w = 0; w < WAYS; w++) begin
        line = mem_q[rd_set][w];
        if (wr_go && wr_set == rd_set && wr_tgt == WAY_W'(w)) line = wr_line;
        rd_data_d[w*LINE_W +: LINE_W] = rd_vbits_d[w] ? line : '0;
      end
      rd_victim_d = (&rd_vbits_d) ? plru_vic : WAY_W'(lowest_one(8'(~rd_vbits_d)));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_go) mem_q[wr_set][wr_tgt] <= wr_line;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      rd_data_q   <= '0;
      rd_vbits_q  <= '0;
      rd_victim_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rd_data_q   <= rd_data_d;
      rd_vbits_q  <= rd_vbits_d;
      rd_victim_q <= rd_victim_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_vbits  = rd_vbits_q;
  assign rd_victim = rd_victim_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_data_array_nway.sv
// Scoreboard bench for data_array_nway with the default geometry (4 ways, 32 sets,
// 256-bit lines, 16-bit words).
module tb_data_array_nway;

  localparam int WAYS   = 4;
  localparam int SETS   = 32;
  localparam int LINE_W = 256;
  localparam int WORD_W = 16;
  localparam int NW     = LINE_W / WORD_W;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   rd_en;
  logic [4:0]             rd_set;
  logic [WAYS*LINE_W-1:0] rd_data;
  logic [WAYS-1:0]        rd_vbits;
  logic [1:0]             rd_victim;
  logic                   rd_valid;
  logic                   wr_en;
  logic [4:0]             wr_set;
  logic [WAYS-1:0]        wr_hit;
  logic [1:0]             wr_fill_way;
  logic [NW-1:0]          wr_mask;
  logic [LINE_W-1:0]      wr_data;
  logic                   touch_en;
  logic [4:0]             touch_set;
  logic [1:0]             touch_way;
  logic                   flush;

  always #5 clk = ~clk;

  data_array_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_W(LINE_W), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_set(rd_set), .rd_data(rd_data), .rd_vbits(rd_vbits),
    .rd_victim(rd_victim), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_set(wr_set), .wr_hit(wr_hit), .wr_fill_way(wr_fill_way),
    .wr_mask(wr_mask), .wr_data(wr_data),
    .touch_en(touch_en), .touch_set(touch_set), .touch_way(touch_way),
    .flush(flush)
  );

  typedef struct {
    logic [WAYS*LINE_W-1:0] data;
    logic [WAYS-1:0]        vb;
    logic [1:0]             vic;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model. PLRU bits: [0] root, [1] node for ways 0/1, [2] node for ways 2/3.
  logic [LINE_W-1:0] m_mem  [SETS][WAYS];
  logic [WAYS-1:0]   m_val  [SETS];
  logic [2:0]        m_plru [SETS];

  function automatic logic [1:0] m_victim(input logic [2:0] p);
    if (p[0]) return p[2] ? 2'd3 : 2'd2;
    else      return p[1] ? 2'd1 : 2'd0;
  endfunction

  task automatic m_touch(input int s, input int w);
    m_plru[s][0] = (w < 2);
    if (w < 2) m_plru[s][1] = (w == 0);
    else       m_plru[s][2] = (w == 2);
  endtask

  task automatic m_clear();
    for (int s = 0; s < SETS; s++) begin
      m_val[s]  = '0;
      m_plru[s] = '0;
    end
  endtask

  // Apply one cycle to the model, queue the expected read response, then clock the DUT.
  task automatic step();
    exp_t              e;
    int                t;
    logic [LINE_W-1:0] l;
    if (flush) begin
      m_clear();
    end else begin
      if (wr_en) begin
        if (wr_hit != 0) begin
          t = wr_hit[0] ? 0 : wr_hit[1] ? 1 : wr_hit[2] ? 2 : 3;
          l = m_mem[wr_set][t];
          for (int k = 0; k < NW; k++)
            if (wr_mask[k]) l[k*WORD_W +: WORD_W] = wr_data[k*WORD_W +: WORD_W];
          m_mem[wr_set][t] = l;
        end else begin
          t = int'(wr_fill_way);
          m_mem[wr_set][t] = wr_data;
          m_val[wr_set][t] = 1'b1;
        end
        m_touch(int'(wr_set), t);
      end
      if (touch_en) m_touch(int'(touch_set), int'(touch_way));
    end
    if (rd_en) begin
      e.vb = m_val[rd_set];
      for (int w = 0; w < WAYS; w++)
        e.data[w*LINE_W +: LINE_W] = e.vb[w] ? m_mem[rd_set][w] : '0;
      if (&e.vb) e.vic = m_victim(m_plru[rd_set]);
      else e.vic = !e.vb[0] ? 2'd0 : !e.vb[1] ? 2'd1 : !e.vb[2] ? 2'd2 : 2'd3;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    rd_en = 1'b0; wr_en = 1'b0; touch_en = 1'b0; flush = 1'b0;
    wr_hit = '0; wr_mask = '0;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_rd_valid: got rd_valid=1, required no response pending");
      end else begin
        mon_e = exp_q.pop_front();
        n_vec++;
        if (rd_data !== mon_e.data) begin
          n_err++;
          for (int w = 0; w < WAYS; w++)
            if (rd_data[w*LINE_W +: LINE_W] !== mon_e.data[w*LINE_W +: LINE_W]) begin
              $display("FAIL rd_data way %0d: got %h required %h", w,
                       rd_data[w*LINE_W +: LINE_W], mon_e.data[w*LINE_W +: LINE_W]);
              break;
            end
        end
        n_vec++;
        if (rd_vbits !== mon_e.vb) begin
          n_err++;
          $display("FAIL rd_vbits: got %b required %b", rd_vbits, mon_e.vb);
        end
        n_vec++;
        if (rd_victim !== mon_e.vic) begin
          n_err++;
          $display("FAIL rd_victim: got %0d required %0d", rd_victim, mon_e.vic);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    m_clear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b required 0", rd_valid); end
    n_vec++; if (rd_vbits !== '0) begin n_err++; $display("FAIL reset_rd_vbits: got %b required 0000", rd_vbits); end
    n_vec++; if (rd_victim !== '0) begin n_err++; $display("FAIL reset_rd_victim: got %0d required 0", rd_victim); end
    n_vec++; if (rd_data !== '0) begin n_err++; $display("FAIL reset_rd_data: got nonzero required 0"); end
    rd_en = 1'b1; rd_set = 5'd5;
    step();
    n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL first_read_valid: got %b required 1", rd_valid); end
    step();
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rd_valid_one_cycle: got %b required 0", rd_valid); end
  endtask

  task automatic test_fill();
    for (int w = 0; w < WAYS; w++) begin
      wr_en = 1'b1; wr_set = 5'd3; wr_hit = '0; wr_fill_way = 2'(w);
      wr_data = {32{8'hA5}};
      step();
    end
    touch_en = 1'b1; touch_set = 5'd3; touch_way = 2'd0;
    step();
    rd_en = 1'b1; rd_set = 5'd3;
    step();
    n_vec++; if (rd_victim !== 2'd2) begin n_err++; $display("FAIL fill_victim: got %0d required 2", rd_victim); end
    n_vec++; if (rd_vbits !== 4'hF) begin n_err++; $display("FAIL fill_vbits: got %b required 1111", rd_vbits); end
  endtask

  task automatic test_hit_write();
    wr_en = 1'b1; wr_set = 5'd3; wr_hit = 4'b0010; wr_mask = 16'h0001;
    wr_data = {{15{16'hFFFF}}, 16'h1234};
    step();
    rd_en = 1'b1; rd_set = 5'd3;
    step();
    n_vec++; if (rd_data[LINE_W +: 16] !== 16'h1234) begin n_err++; $display("FAIL hit_word0: got %h required 1234", rd_data[LINE_W +: 16]); end
    n_vec++; if (rd_data[LINE_W+16 +: 16] !== 16'hA5A5) begin n_err++; $display("FAIL hit_word1: got %h required a5a5", rd_data[LINE_W+16 +: 16]); end
    // Outputs hold when no read is issued.
    step();
    n_vec++; if (rd_data[LINE_W +: 16] !== 16'h1234 || rd_valid !== 1'b0) begin
      n_err++; $display("FAIL hold_after_read: got word %h valid %b required 1234 and 0", rd_data[LINE_W +: 16], rd_valid);
    end
    // Same-cycle hit write (multi-bit hit, lowest bit wins) and read: merged bypass.
    wr_en = 1'b1; wr_set = 5'd3; wr_hit = 4'b1100; wr_mask = 16'h8001;
    wr_data = {16'hBEEF, {14{16'h0000}}, 16'hCAFE};
    rd_en = 1'b1; rd_set = 5'd3;
    step();
    // A zero mask changes no data.
    wr_en = 1'b1; wr_set = 5'd3; wr_hit = 4'b0001; wr_mask = '0; wr_data = '0;
    rd_en = 1'b1; rd_set = 5'd3;
    step();
  endtask

  task automatic test_bypass_fill();
    wr_en = 1'b1; wr_set = 5'd7; wr_hit = '0; wr_fill_way = 2'd2;
    wr_data = {16{16'hDEAD}};
    rd_en = 1'b1; rd_set = 5'd7;
    step();
    n_vec++; if (rd_data[2*LINE_W +: LINE_W] !== {16{16'hDEAD}} || rd_vbits[2] !== 1'b1) begin
      n_err++; $display("FAIL bypass_fill: got vbits %b way2 %h required bit2=1 dead..", rd_vbits, rd_data[2*LINE_W +: 32]);
    end
  endtask

  task automatic test_write_touch_order();
    for (int w = 0; w < WAYS; w++) begin
      wr_en = 1'b1; wr_set = 5'd9; wr_hit = '0; wr_fill_way = 2'(w);
      for (int k = 0; k < 8; k++) wr_data[k*32 +: 32] = $urandom();
      step();
    end
    wr_en = 1'b1; wr_set = 5'd9; wr_hit = 4'b0010; wr_mask = 16'h00F0;
    for (int k = 0; k < 8; k++) wr_data[k*32 +: 32] = $urandom();
    touch_en = 1'b1; touch_set = 5'd9; touch_way = 2'd2;
    step();
    rd_en = 1'b1; rd_set = 5'd9;
    step();
    n_vec++; if (rd_victim !== 2'd0) begin n_err++; $display("FAIL write_then_touch_victim: got %0d required 0", rd_victim); end
  endtask

  task automatic test_flush();
    flush = 1'b1; rd_en = 1'b1; rd_set = 5'd7;
    step();
    n_vec++; if (rd_vbits !== '0 || rd_data !== '0 || rd_victim !== '0) begin
      n_err++; $display("FAIL flush_same_cycle_read: got vbits %b victim %0d required 0000 and 0", rd_vbits, rd_victim);
    end
    wr_en = 1'b1; wr_set = 5'd3; wr_hit = '0; wr_fill_way = 2'd1; wr_data = {32{8'h3C}};
    touch_en = 1'b1; touch_set = 5'd3; touch_way = 2'd1;
    flush = 1'b1;
    step();
    rd_en = 1'b1; rd_set = 5'd3;
    step();
    n_vec++; if (rd_vbits !== '0 || rd_data !== '0 || rd_victim !== '0) begin
      n_err++; $display("FAIL flush_drops_write: got vbits %b victim %0d required 0000 and 0", rd_vbits, rd_victim);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] sets [4];
    sets[0] = 5'd1; sets[1] = 5'd2; sets[2] = 5'd4; sets[3] = 5'd8;
    for (int c = 0; c < 400; c++) begin
      rd_en     = ($urandom_range(0, 9) < 7);
      rd_set    = sets[$urandom_range(0, 3)];
      wr_en     = ($urandom_range(0, 1) == 1);
      wr_set    = sets[$urandom_range(0, 3)];
      wr_hit    = ($urandom_range(0, 1) == 1) ? 4'(($urandom_range(1, 15))) : 4'h0;
      wr_fill_way = 2'($urandom_range(0, 3));
      wr_mask   = 16'($urandom());
      for (int k = 0; k < 8; k++) wr_data[k*32 +: 32] = $urandom();
      touch_en  = ($urandom_range(0, 9) < 4);
      touch_set = sets[$urandom_range(0, 3)];
      touch_way = 2'($urandom_range(0, 3));
      flush     = ($urandom_range(0, 99) < 3);
      step();
    end
    step();
  endtask

  task automatic test_reset_midread();
    rd_en = 1'b1; rd_set = 5'd3;
    step();
    rst_n = 1'b0;
    exp_q.delete();
    m_clear();
    #1;
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_drops_rd_valid: got %b required 0", rd_valid); end
    repeat (2) begin
      @(negedge clk);
      n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rd_valid_in_reset: got %b required 0", rd_valid); end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rd_valid_after_release: got %b required 0", rd_valid); end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_en = 1'b0; rd_set = '0; wr_en = 1'b0; wr_set = '0; wr_hit = '0;
    wr_fill_way = '0; wr_mask = '0; wr_data = '0; touch_en = 1'b0;
    touch_set = '0; touch_way = '0; flush = 1'b0;
    do_reset();
    test_reset();
    test_fill();
    test_hit_write();
    test_bypass_fill();
    test_write_touch_order();
    test_flush();
    test_back_to_back();
    test_reset_midread();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_responses: got %0d outstanding required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
